dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder: the memory-side end of the core's load/store interface. It accepts one load or store request at a time over a valid/ready handshake and emulates a RAM with programmable wait states. Stores are byte, half or word sized; loads are sign- or zero-extended. Each request returns exactly one response through a second valid/ready handshake. It sits between the processor top level and the data storage, so multi-cycle memory can be exercised against the core.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words
- WAIT_CYCLES, 2, extra cycles between accept and access, legal 0..15
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0] encoding)
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0 (funct3[2]); ignored for stores
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request

## Operation
- FSM states: IDLE, WAIT, RESP.
  - Request handshake: req_valid && req_ready at a rising edge.
  - Response handshake: rsp_valid && rsp_ready at a rising edge.
- IDLE:
  - req_ready = 1 (decoded from state).
  - On a request handshake: latch we/addr/size/unsigned/wdata, load cnt = WAIT_CYCLES, go WAIT.
- WAIT:
  - req_ready = 0.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access and go RESP.
- Access in WAIT with cnt == 0:
  - Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo depth.
  - Error when size 11, or half with addr[0]=1, or word with addr[1:0]!=0. On error: no memory write, rsp_err = 1, rsp_rdata = 0.
  - Store writes only the addressed lanes:
    - byte → lane addr[1:0]
    - half → lanes addr[1]*2 and addr[1]*2+1
    - word → all four lanes
  - Store leaves rsp_rdata = 0.
  - Load selects the lane(s) and extends to 32 bits per req_unsigned; the result is registered into rsp_rdata.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the response handshake, then go IDLE.
  - req_ready = 0 in RESP, so no new request is accepted in the response-handshake cycle.
- Store then load to the same word returns the new data (the write has committed before RESP).
- Memory contents are not cleared by reset; initial contents are undefined unless preloaded by the bench.

## Timing
- Reset, taking effect at the first rising edge with reset = 1:
  - state = IDLE, cnt = 0
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
- Latency: request handshake at edge T → rsp_valid high after edge T+WAIT_CYCLES+1. With WAIT_CYCLES = 0, rsp_valid is high one cycle after accept.
- Throughput: at most one request per WAIT_CYCLES+3 cycles, with rsp_ready held high.
- Backpressure: with rsp_ready held low, the FSM stays in RESP indefinitely and outputs do not change.
- Reset mid-operation:
  - Reset in WAIT drops the request. A store whose access edge coincides with the reset edge is not written; reset has priority.
  - Reset in RESP drops the pending response; rsp_valid = 0 after that edge.
- req_* inputs are sampled only at the request-handshake edge; later changes have no effect.

## Test plan
- Word store/load, WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, then load addr 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid exactly 3 cycles after each accept.
- Byte lanes and extension: word 0x0 = 0x80FF7F01.
  - Load byte addr 0x3 signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Load half addr 0x2 signed → 0xFFFF80FF.
  - Store byte 0xAA at addr 0x1, then load word → 0x80FFAA01.
- Misalignment: load half at 0x5, load word at 0x6, store size 11 at 0x8 → each gives rsp_err 1, rsp_rdata 0. Word 0x8 is unchanged on a later word load.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid → rsp_valid and rsp_rdata are stable and req_ready stays 0; raising rsp_ready gives IDLE, with req_ready = 1 the next cycle.
- Reset mid-op: accept store 0x12345678 to 0x20, assert reset during WAIT → rsp_valid stays 0 and a subsequent load of 0x20 returns the previous contents. Reset during RESP → rsp_valid = 0 next cycle.
- Wrap and zero-wait: with WAIT_CYCLES=0 and ADDR_WIDTH=10, store at 0x1000 then load at 0x0 → same data, rsp_valid one cycle after each accept.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between a core-side initiator and the data-memory responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store RAM model with programmable wait states,
// byte/half/word lanes, sign/zero-extended loads and misalignment errors.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [31:0]           wdata_q;

   logic [31:0]           mem [DEPTH];

   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            off;
   logic                  access;
   logic                  err_c;
   logic [3:0]            be;
   logic [31:0]           wlanes;
   logic [31:0]           rd_word;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [31:0]           load_data;
   logic                  unused_addr_hi;

   // Address bits above the word index are deliberately dropped so accesses wrap modulo depth.
   assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

   assign idx     = addr_q[ADDR_WIDTH+1:2];
   assign off     = addr_q[1:0];
   assign access  = (state == WAIT) && (cnt == 4'd0);
   assign rd_word = mem[idx];

   always_comb begin
      err_c = 1'b0;
      case (size_q)
         2'b01:   err_c = off[0];
         2'b10:   err_c = (off != 2'b00);
         2'b11:   err_c = 1'b1;
         default: err_c = 1'b0;
      endcase
   end

   // Right-aligned store data is replicated across lanes; byte enables pick the live ones.
   always_comb begin
      be     = '0;
      wlanes = wdata_q;
      case (size_q)
         2'b00: begin
            be[off] = 1'b1;
            wlanes  = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be     = off[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{wdata_q[15:0]}};
         end
         2'b10:   be = '1;
         default: be = '0;
      endcase
   end

   always_comb begin
      lane_b    = 8'(rd_word >> {off, 3'b000});
      lane_h    = off[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = rd_word;
      case (size_q)
         2'b00:   load_data = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   load_data = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_data = rd_word;
      endcase
   end

   // Storage is never reset; reset only blocks a write landing on the same edge.
   always_ff @(posedge clk) begin
      if (!reset && access && we_q && !err_c) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wlanes[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q          <= bus.req_we;
                  addr_q        <= bus.req_addr[ADDR_WIDTH+1:0];
                  size_q        <= bus.req_size;
                  uns_q         <= bus.req_unsigned;
                  wdata_q       <= bus.req_wdata;
                  cnt           <= 4'(WAIT_CYCLES);
                  bus.req_ready <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= err_c;
                  bus.rsp_rdata <= (err_c || we_q) ? '0 : load_data;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b0;
                  bus.req_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.req_ready <= 1'b1;
               bus.rsp_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts each response,
// and per-DUT monitors compare data, error, latency and hold behaviour.
module tb_dmem_responder;
   localparam int unsigned WAIT_A = 2;
   localparam int unsigned WAIT_B = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus_a ();
   dmem_responder_if bus_b ();

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_A)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_B)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

   int unsigned tests  = 0;
   int unsigned failed = 0;
   int unsigned cyc    = 0;
   int unsigned bp_mode = 1;   // 0 random, 1 always ready, 2 held low

   logic [7:0]  model [2][4096];
   exp_t        q_a [$];
   exp_t        q_b [$];
   logic        prev_v  [2];
   logic        prev_hs [2];
   logic [31:0] hold_d  [2];
   logic        hold_e  [2];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      case (bp_mode)
         0:       bus_a.rsp_ready = ($urandom_range(0, 3) != 0);
         2:       bus_a.rsp_ready = 1'b0;
         default: bus_a.rsp_ready = 1'b1;
      endcase
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic exp_t model_access(input int d, input logic we, input logic [31:0] a,
                                         input logic [1:0] sz, input logic u, input logic [31:0] wd);
      exp_t e;
      int unsigned nb, base;
      logic [31:0] v, w;
      e.rdata = '0;
      e.err   = 1'b0;
      e.acc   = 0;
      base = a % 4096;
      if (sz == 2'b11) begin
         e.err = 1'b1;
         return e;
      end
      nb = 1 << sz;
      if (base % nb != 0) begin
         e.err = 1'b1;
         return e;
      end
      if (we) begin
         w = wd;
         for (int unsigned i = 0; i < nb; i++) begin
            model[d][base + i] = w[7:0];
            w = w >> 8;
         end
      end else begin
         v = '0;
         for (int i = int'(nb) - 1; i >= 0; i--) v = (v << 8) | 32'(model[d][base + i]);
         if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
         e.rdata = v;
      end
      return e;
   endfunction

   function automatic logic get_ready(input int d);
      return (d == 0) ? bus_a.req_ready : bus_b.req_ready;
   endfunction

   function automatic logic get_valid(input int d);
      return (d == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
   endfunction

   task automatic set_req(input int d, input logic v, input logic we, input logic [31:0] a,
                          input logic [1:0] sz, input logic u, input logic [31:0] wd);
      if (d == 0) begin
         bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a;
         bus_a.req_size = sz; bus_a.req_unsigned = u; bus_a.req_wdata = wd;
      end else begin
         bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a;
         bus_b.req_size = sz; bus_b.req_unsigned = u; bus_b.req_wdata = wd;
      end
   endtask

   task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input bit drop);
      int unsigned n = 0;
      exp_t e;
      @(posedge clk); #1;
      while (!get_ready(d) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         check("req_ready_timeout", 32'(get_ready(d)), 32'd1);
         return;
      end
      set_req(d, 1'b1, we, a, sz, u, wd);
      @(posedge clk); #1;
      // Scramble the request fields after acceptance; the DUT must have latched them.
      set_req(d, 1'b0, 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom);
      if (!drop) begin
         e = model_access(d, we, a, sz, u, wd);
         e.acc = cyc;
         if (d == 0) q_a.push_back(e); else q_b.push_back(e);
      end
   endtask

   task automatic drain(input int d);
      int unsigned n = 0;
      while (n < 500 && !(((d == 0) ? q_a.size() : q_b.size()) == 0 && get_ready(d))) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) check("drain_timeout", 32'(n), 32'd0);
   endtask

   task automatic wait_valid(input int d);
      int unsigned n = 0;
      while (!get_valid(d) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("rsp_valid_timeout", 32'(get_valid(d)), 32'd1);
   endtask

   task automatic mon_step(input int d);
      logic        v, r, rr, e;
      logic [31:0] dat;
      exp_t        x;
      v   = (d == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
      r   = (d == 0) ? bus_a.req_ready : bus_b.req_ready;
      rr  = (d == 0) ? bus_a.rsp_ready : bus_b.rsp_ready;
      dat = (d == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
      e   = (d == 0) ? bus_a.rsp_err   : bus_b.rsp_err;
      if (rst) begin
         prev_v[d]  = 1'b0;
         prev_hs[d] = 1'b0;
         return;
      end
      if (v) begin
         check("req_ready_in_resp", 32'(r), 32'd0);
         if (!prev_v[d]) begin
            if (((d == 0) ? q_a.size() : q_b.size()) == 0) begin
               check("unexpected_rsp", 32'(v), 32'd0);
            end else begin
               x = (d == 0) ? q_a.pop_front() : q_b.pop_front();
               check("rsp_rdata", dat, x.rdata);
               check("rsp_err", 32'(e), 32'(x.err));
               check("latency", cyc, x.acc + ((d == 0) ? WAIT_A : WAIT_B) + 1);
            end
            hold_d[d] = dat;
            hold_e[d] = e;
         end else begin
            check("hold_rdata", dat, hold_d[d]);
            check("hold_err", 32'(e), 32'(hold_e[d]));
         end
      end else if (prev_hs[d]) begin
         check("req_ready_after_rsp", 32'(r), 32'd1);
      end
      prev_v[d]  = v;
      prev_hs[d] = v && rr;
   endtask

   always @(negedge clk) mon_step(0);
   always @(negedge clk) mon_step(1);

   task automatic check_idle(input string name);
      @(negedge clk);
      check({name, "_req_ready"}, 32'(bus_a.req_ready), 32'd1);
      check({name, "_rsp_valid"}, 32'(bus_a.rsp_valid), 32'd0);
      check({name, "_rsp_rdata"}, bus_a.rsp_rdata, 32'd0);
      check({name, "_rsp_err"},   32'(bus_a.rsp_err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      set_req(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      bus_b.rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("reset");
      check("reset_b_req_ready", 32'(bus_b.req_ready), 32'd1);
      check("reset_b_rsp_valid", 32'(bus_b.rsp_valid), 32'd0);

      for (int unsigned w = 0; w < 64; w++) issue(0, 1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 1'b0);

      issue(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
      issue(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h80FF7F01, 1'b0);
      issue(0, 1'b0, 32'h3, 2'b00, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b0, 32'h3, 2'b00, 1'b1, 32'h0, 1'b0);
      issue(0, 1'b0, 32'h2, 2'b01, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h1, 2'b00, 1'b0, 32'h000000AA, 1'b0);
      issue(0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b0, 32'h5, 2'b01, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b0, 32'h6, 2'b10, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h8, 2'b11, 1'b0, 32'hFFFFFFFF, 1'b0);
      issue(0, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 1'b0);
      drain(0);

      bp_mode = 2;
      issue(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0);
      wait_valid(0);
      repeat (5) @(posedge clk);
      #1 bp_mode = 1;
      drain(0);

      // Reset at 1, 2 and 3 edges after accept; the last coincides with the access edge.
      for (int unsigned dly = 0; dly < 3; dly++) begin
         issue(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678, 1'b1);
         repeat (dly) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         check_idle("reset_wait");
         repeat (4) @(negedge clk);
         check("no_rsp_after_reset", 32'(bus_a.rsp_valid), 32'd0);
         issue(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b0);
         drain(0);
      end

      bp_mode = 2;
      issue(0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
      wait_valid(0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bp_mode = 1;
      check_idle("reset_resp");

      bp_mode = 0;
      for (int unsigned k = 0; k < 300; k++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
         issue(0, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, 1'b0);
      end
      drain(0);
      bp_mode = 1;

      for (int unsigned w = 0; w < 64; w++) issue(1, 1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 1'b0);
      issue(1, 1'b1, 32'h1000, 2'b10, 1'b0, $urandom, 1'b0);
      issue(1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
      for (int unsigned k = 0; k < 100; k++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
         issue(1, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, 1'b0);
      end
      drain(1);

      check("queue_a_empty", 32'(q_a.size()), 32'd0);
      check("queue_b_empty", 32'(q_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
